alu_arbiter: RTL
================

Name: alu_arbiter

Overview:
- Shares one instance of the existing combinational ALU between N_REQ requesters. Typical requesters are the main execute path and a separate branch-compare / address unit.
- Each requester uses a valid/ready handshake. A round-robin grant picks one operation per cycle.
- The ALU output is registered into a single response slot with valid/ready back-pressure, so the ALU can later be retimed or made multi-cycle without touching requesters.

Parameters:
- N_REQ, 2, number of requesters (2..4).
- ID_W, 1, width of granted-requester index; must be >= clog2(N_REQ) and >= 1.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- Reset  in  1  synchronous reset, active high.
- req_valid  in  N_REQ  per-requester operation valid.
- req_ready  out  N_REQ  per-requester accept; one-hot or zero.
- req_op  in  3*N_REQ  per-requester ALU opcode; slice i is [3i+2:3i].
- req_a  in  32*N_REQ  per-requester operand a (shift amount for op 010).
- req_b  in  32*N_REQ  per-requester operand b.
- rsp_valid  out  1  response slot holds a result.
- rsp_ready  in  1  consumer takes the response this cycle.
- rsp_id  out  ID_W  index of the requester that issued the held result.
- rsp_result  out  32  registered ALU result.
- rsp_zero  out  1  registered: rsp_result == 0.
- rsp_sign  out  1  registered: rsp_result[31].

Behaviour:
- Reset (synchronous, Reset=1 at CLK edge):
  - rsp_valid=0; rsp_id=0; rsp_result=0; rsp_zero=0; rsp_sign=0.
  - rr_ptr=0.
  - Any held response is discarded, including a reset in the same cycle as a grant.
  - req_ready=0 while Reset is high.
- Slot free: slot_free = !rsp_valid || rsp_ready. This is combinational.
- Grant (combinational):
  - If slot_free, scan requesters starting at rr_ptr, wrapping modulo N_REQ.
  - The first i with req_valid[i]=1 gets req_ready[i]=1. All other bits are 0.
  - If no requester is valid, or the slot is not free, req_ready is all zero.
- Datapath:
  - The granted slice's op, a and b are muxed into the single ALU instance.
  - ALU opcodes: 000 add, 001 sub, 010 b<<a, 011 or, 100 and, 101 unsigned a<b, 110 signed a<b, 111 xnor. All arithmetic is 32-bit wrap-around.
- Capture on the edge where a grant occurs:
  - rsp_result <= ALU result; rsp_zero <= ALU zero; rsp_sign <= ALU sign; rsp_id <= granted index; rsp_valid <= 1.
  - rr_ptr <= (granted index + 1) mod N_REQ.
  - Latency is 1 cycle from the accept edge to rsp_valid.
- Drain without a new grant:
  - rsp_valid && rsp_ready with no grant sets rsp_valid <= 0.
  - The rsp_* data registers hold their last values.
- Simultaneous drain and grant: the slot is overwritten with the new result and rsp_valid stays 1. Sustained throughput is 1 op per cycle.
- Stall: while rsp_valid && !rsp_ready, all rsp_* outputs are stable, req_ready=0, and rr_ptr is unchanged.
- rr_ptr changes only on a grant. An idle cycle does not move priority.
- Requester rule: once req_valid[i] is asserted it stays high, and the slice stays stable, until req_ready[i]. The bench asserts this rule; the RTL does not check it.
- Fairness: with all requesters continuously valid and rsp_ready=1, grants rotate 0,1,...,N_REQ-1,0. No requester waits more than N_REQ-1 grants.
- States:
  - EMPTY (rsp_valid=0): goes to FULL on a grant.
  - FULL (rsp_valid=1): goes to EMPTY on drain without a grant. Stays FULL on a stall, or on drain with a grant.
  - rsp_valid alone encodes the state; no separate state register.

Decomposition:
- Shared package alu_pkg:
  - opcode constants ALU_ADD=3'b000 .. ALU_XNOR=3'b111.
  - ALU data width constant 32.
  - These are reused by the control unit.
- One sub-module: the existing ALU, instantiated unchanged. Connections: ALUopcode, rega, regb, result, zero, sign.
- Round-robin grant logic stays inline. A separate rr_arbiter module is not justified at N_REQ<=4.

Test Plan:
- Single add: requester 0 issues op 000, a=5, b=7, rsp_ready=1. Expect req_ready[0]=1 the same cycle. Next cycle expect rsp_valid=1, rsp_result=12, rsp_zero=0, rsp_sign=0, rsp_id=0.
- Sub and compares:
  - Requester 1: op 001, a=3, b=3 -> result 0, zero=1.
  - Then op 110, a=32'hFFFFFFFF, b=1 -> result 1.
  - Then op 101 with the same operands -> result 0.
  - Then op 010, a=4, b=1 -> result 16.
- Contention: both requesters hold valid with rsp_ready=1 for 6 cycles. Expect grants 0,1,0,1,0,1, back-to-back rsp_valid, and matching rsp_id.
- Back-pressure: hold rsp_ready=0 for 3 cycles after a result (op 000, a=32'hFFFFFFFF, b=1). Expect result 0, zero=1, all outputs stable, req_ready=0. Release -> the next pending op is granted on the same edge as the drain.
- Reset mid-operation: assert Reset on the edge where a grant occurs with rsp_valid=1. Next cycle expect rsp_valid=0 and rr_ptr=0 (requester 0 wins the next contention).
- Idle priority: grant requester 0, idle 5 cycles, then both valid. Expect requester 1 granted first.

Source files
------------

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared ALU definitions: datapath width and opcode encoding. Used by the ALU,
// the arbiter interface and the arbiter control logic.
// No ports (package).
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam int ALU_W = 32;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'b000,  // a + b
        ALU_SUB  = 3'b001,  // a - b
        ALU_SLL  = 3'b010,  // b << a (a is the shift amount)
        ALU_OR   = 3'b011,  // a | b
        ALU_AND  = 3'b100,  // a & b
        ALU_SLTU = 3'b101,  // unsigned a < b
        ALU_SLT  = 3'b110,  // signed a < b
        ALU_XNOR = 3'b111   // ~(a ^ b)
    } alu_op_e;

endpackage

// File: rtl/alu_arbiter_if.sv
// -----------------------------------------------------------------------------
// alu_arbiter_if
// Bundles the requester side (N_REQ valid/ready lanes with op/a/b slices) and
// the single registered response slot of the shared ALU.
//   master : requesters + response consumer (drives req_*, rsp_ready)
//   slave  : the arbiter (drives req_ready, rsp_*)
// Slice i of req_op is [3i+2:3i]; slice i of req_a/req_b is [32i+31:32i].
// -----------------------------------------------------------------------------
interface alu_arbiter_if #(
    parameter int N_REQ = 2,
    parameter int ID_W  = 1
);
    import alu_pkg::*;

    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ-1:0]       req_ready;
    logic [3*N_REQ-1:0]     req_op;
    logic [ALU_W*N_REQ-1:0] req_a;
    logic [ALU_W*N_REQ-1:0] req_b;

    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [ID_W-1:0]        rsp_id;
    logic [ALU_W-1:0]       rsp_result;
    logic                   rsp_zero;
    logic                   rsp_sign;

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_sign
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_sign
    );

endinterface

// File: rtl/alu_arbiter_alu.sv
// -----------------------------------------------------------------------------
// alu
// The existing purely combinational 32-bit ALU.
//   ALUopcode : operation select (see alu_pkg::alu_op_e)
//   rega/regb : operands; rega is the shift amount for the shift op
//   result    : 32-bit wrap-around result
//   zero      : result == 0
//   sign      : result[31]
// -----------------------------------------------------------------------------
module alu
    import alu_pkg::*;
(
    input  logic [2:0]       ALUopcode,
    input  logic [ALU_W-1:0] rega,
    input  logic [ALU_W-1:0] regb,
    output logic [ALU_W-1:0] result,
    output logic             zero,
    output logic             sign
);

    always_comb begin
        result = '0;
        case (alu_op_e'(ALUopcode))
            ALU_ADD:  result = rega + regb;
            ALU_SUB:  result = rega - regb;
            // Full 32-bit shift amount: any amount >= 32 yields zero.
            ALU_SLL:  result = regb << rega;
            ALU_OR:   result = rega | regb;
            ALU_AND:  result = rega & regb;
            ALU_SLTU: result = {{(ALU_W-1){1'b0}}, (rega < regb)};
            ALU_SLT:  result = {{(ALU_W-1){1'b0}}, ($signed(rega) < $signed(regb))};
            ALU_XNOR: result = ~(rega ^ regb);
            default:  result = '0;
        endcase
    end

    assign zero = (result == '0);
    assign sign = result[ALU_W-1];

endmodule

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
// Shares one combinational ALU between N_REQ requesters. A round-robin grant
// picks at most one operation per cycle; the ALU output is captured into a
// single response slot with valid/ready back-pressure.
//   CLK   : clock, all state on the rising edge
//   Reset : synchronous, active high; empties the slot and resets priority
//   bus   : alu_arbiter_if slave modport (request lanes + response slot)
// The slot occupancy (rsp_valid) is the only control state: EMPTY/FULL.
// -----------------------------------------------------------------------------
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int ID_W  = 1
) (
    input  logic         CLK,
    input  logic         Reset,
    alu_arbiter_if.slave bus
);

    // Per-requester views of the flat request buses.
    logic [2:0]       op_arr [N_REQ];
    logic [ALU_W-1:0] a_arr  [N_REQ];
    logic [ALU_W-1:0] b_arr  [N_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_slice
            assign op_arr[gi] = bus.req_op[3*gi +: 3];
            assign a_arr[gi]  = bus.req_a[ALU_W*gi +: ALU_W];
            assign b_arr[gi]  = bus.req_b[ALU_W*gi +: ALU_W];
        end
    endgenerate

    // Response slot and round-robin pointer.
    logic             rsp_valid_q;
    logic [ID_W-1:0]  rsp_id_q;
    logic [ALU_W-1:0] rsp_result_q;
    logic             rsp_zero_q;
    logic             rsp_sign_q;
    logic [ID_W-1:0]  rr_ptr_q;
    logic [ID_W-1:0]  rr_ptr_d;

    // Grant and ALU input mux.
    logic             slot_free;
    logic             grant_valid;
    logic [ID_W-1:0]  grant_idx;
    logic [N_REQ-1:0] grant_vec;
    logic [2:0]       alu_op;
    logic [ALU_W-1:0] alu_a;
    logic [ALU_W-1:0] alu_b;
    logic [ALU_W-1:0] alu_result;
    logic             alu_zero;
    logic             alu_sign;
    int               idx;

    always_comb begin
        // The slot can take a new result if empty or being drained this cycle.
        slot_free   = !rsp_valid_q || bus.rsp_ready;
        grant_valid = 1'b0;
        grant_idx   = '0;
        grant_vec   = '0;
        alu_op      = '0;
        alu_a       = '0;
        alu_b       = '0;
        idx         = 0;
        if (slot_free && !Reset) begin
            // Scan from rr_ptr, wrapping; the first valid requester wins.
            for (int k = 0; k < N_REQ; k++) begin
                idx = (int'(rr_ptr_q) + k) % N_REQ;
                if (!grant_valid && bus.req_valid[idx]) begin
                    grant_valid    = 1'b1;
                    grant_idx      = ID_W'(idx);
                    grant_vec[idx] = 1'b1;
                    alu_op         = op_arr[idx];
                    alu_a          = a_arr[idx];
                    alu_b          = b_arr[idx];
                end
            end
        end
        // Winner drops to lowest priority for the next scan.
        rr_ptr_d = ID_W'((int'(grant_idx) + 1) % N_REQ);
    end

    alu u_alu (
        .ALUopcode (alu_op),
        .rega      (alu_a),
        .regb      (alu_b),
        .result    (alu_result),
        .zero      (alu_zero),
        .sign      (alu_sign)
    );

    always_ff @(posedge CLK) begin
        if (Reset) begin
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_sign_q   <= 1'b0;
            rr_ptr_q     <= '0;
        end else if (grant_valid) begin
            // Covers both EMPTY->FULL and drain-with-grant (slot overwrite).
            rsp_valid_q  <= 1'b1;
            rsp_id_q     <= grant_idx;
            rsp_result_q <= alu_result;
            rsp_zero_q   <= alu_zero;
            rsp_sign_q   <= alu_sign;
            rr_ptr_q     <= rr_ptr_d;
        end else if (rsp_valid_q && bus.rsp_ready) begin
            // Drain without refill: data registers keep their last values.
            rsp_valid_q  <= 1'b0;
        end
    end

    assign bus.req_ready  = grant_vec;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_zero   = rsp_zero_q;
    assign bus.rsp_sign   = rsp_sign_q;

endmodule
